// File: rtl/proc_pkg.sv
// Shared definitions for the processor sequencing control: opcodes, timing-step
// encoding and instruction-register field positions.
package proc_pkg;

    localparam int NREG = 8;

    localparam int IR_W  = 9;
    localparam int OP_HI = 8;
    localparam int OP_LO = 6;
    localparam int RX_HI = 5;
    localparam int RX_LO = 3;
    localparam int RY_HI = 2;
    localparam int RY_LO = 0;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

endpackage

// File: rtl/proc_control_if.sv
// Control-to-datapath bundle: run/instruction input plus all strobes and bus selects.
// master = the control unit, slave = the datapath / stimulus side.
interface proc_control_if #(
    parameter int N = 16
);
    import proc_pkg::*;

    logic                run;
    logic [N-1:0]        din;
    logic                ir_in;
    logic [NREG-1:0]     r_in;
    logic [NREG-1:0]     r_out;
    logic                a_in;
    logic                g_in;
    logic                g_out;
    logic                din_out;
    logic                add_sub;
    logic                done;

    modport master (
        input  run, din,
        output ir_in, r_in, r_out, a_in, g_in, g_out, din_out, add_sub, done
    );

    modport slave (
        output run, din,
        input  ir_in, r_in, r_out, a_in, g_in, g_out, din_out, add_sub, done
    );

endinterface

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
// Purely combinational.
module dec3to8 (
    input  logic [2:0] w,
    input  logic       en,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        if (en) y[w] = 1'b1;
    end

endmodule

// File: rtl/proc_control.sv
// Four-step (T0..T3) sequencing control: fetches a 9-bit instruction and issues
// datapath strobes combinationally from step, IR and run; done marks retirement.
module proc_control
    import proc_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    proc_control_if.master bus
);

    state_t          state;
    logic [IR_W-1:0] ir;

    logic [2:0] op, rx, ry;
    assign op = ir[OP_HI:OP_LO];
    assign rx = ir[RX_HI:RX_LO];
    assign ry = ir[RY_HI:RY_LO];

    logic       rin_en, rout_en;
    logic [2:0] rin_sel, rout_sel;
    logic       ir_in, a_in, g_in, g_out, din_out, add_sub, done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= T0;
            ir    <= '0;
        end else begin
            unique case (state)
                T0: if (bus.run) begin
                    ir    <= bus.din[IR_W-1:0];
                    state <= T1;
                end
                T1: state <= (op == OP_ADD || op == OP_SUB) ? T2 : T0;
                T2: state <= T3;
                T3: state <= T0;
                default: state <= T0;
            endcase
        end
    end

    // Reset forces state to T0 asynchronously, so gating ir_in is all that is
    // needed to hold every output at its reset value while reset is high.
    always_comb begin
        ir_in    = 1'b0;
        a_in     = 1'b0;
        g_in     = 1'b0;
        g_out    = 1'b0;
        din_out  = 1'b0;
        add_sub  = 1'b1;
        done     = 1'b0;
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rin_sel  = rx;
        rout_sel = rx;
        unique case (state)
            T0: ir_in = bus.run & ~reset;
            T1: begin
                unique case (op)
                    OP_MV: begin
                        rout_en  = 1'b1;
                        rout_sel = ry;
                        rin_en   = 1'b1;
                        done     = 1'b1;
                    end
                    OP_MVI: begin
                        din_out = 1'b1;
                        rin_en  = 1'b1;
                        done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_en = 1'b1;
                        a_in    = 1'b1;
                    end
                    default: done = 1'b1;
                endcase
            end
            T2: begin
                rout_en  = 1'b1;
                rout_sel = ry;
                g_in     = 1'b1;
                add_sub  = (op == OP_ADD);
            end
            T3: begin
                g_out  = 1'b1;
                rin_en = 1'b1;
                done   = 1'b1;
            end
            default: ;
        endcase
    end

    dec3to8 u_rin_dec (
        .w  (rin_sel),
        .en (rin_en),
        .y  (bus.r_in)
    );

    dec3to8 u_rout_dec (
        .w  (rout_sel),
        .en (rout_en),
        .y  (bus.r_out)
    );

    assign bus.ir_in   = ir_in;
    assign bus.a_in    = a_in;
    assign bus.g_in    = g_in;
    assign bus.g_out   = g_out;
    assign bus.din_out = din_out;
    assign bus.add_sub = add_sub;
    assign bus.done    = done;

endmodule

// File: tb/tb_proc_control.sv
// Bench for proc_control: directed test-plan sequences plus random traffic, checked
// against a queue of per-cycle control words built from each fetched instruction.
module tb_proc_control;

    typedef struct packed {
        logic       ir_in;
        logic [7:0] r_in;
        logic [7:0] r_out;
        logic       a_in;
        logic       g_in;
        logic       g_out;
        logic       din_out;
        logic       add_sub;
        logic       done;
    } cw_t;

    localparam cw_t IDLE_W = '{ir_in: 1'b0, r_in: 8'h00, r_out: 8'h00, a_in: 1'b0,
                               g_in: 1'b0, g_out: 1'b0, din_out: 1'b0, add_sub: 1'b1,
                               done: 1'b0};

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    proc_control_if #(.N(16)) bus ();

    proc_control dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    int  n_checks = 0;
    int  n_fails  = 0;
    cw_t exp_q[$];
    cw_t obs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic cw_t sample_dut();
        cw_t w;
        w.ir_in   = bus.ir_in;
        w.r_in    = bus.r_in;
        w.r_out   = bus.r_out;
        w.a_in    = bus.a_in;
        w.g_in    = bus.g_in;
        w.g_out   = bus.g_out;
        w.din_out = bus.din_out;
        w.add_sub = bus.add_sub;
        w.done    = bus.done;
        return w;
    endfunction

    // Expected micro-steps of one instruction, one control word per cycle after fetch.
    task automatic push_instr(input logic [15:0] d);
        logic [2:0] op, rx, ry;
        cw_t w;
        op = d[8:6];
        rx = d[5:3];
        ry = d[2:0];
        case (op)
            3'd0: begin
                w = IDLE_W; w.r_out = 8'h01 << ry; w.r_in = 8'h01 << rx; w.done = 1'b1;
                exp_q.push_back(w);
            end
            3'd1: begin
                w = IDLE_W; w.din_out = 1'b1; w.r_in = 8'h01 << rx; w.done = 1'b1;
                exp_q.push_back(w);
            end
            3'd2, 3'd3: begin
                w = IDLE_W; w.r_out = 8'h01 << rx; w.a_in = 1'b1;
                exp_q.push_back(w);
                w = IDLE_W; w.r_out = 8'h01 << ry; w.g_in = 1'b1; w.add_sub = (op == 3'd2);
                exp_q.push_back(w);
                w = IDLE_W; w.g_out = 1'b1; w.r_in = 8'h01 << rx; w.done = 1'b1;
                exp_q.push_back(w);
            end
            default: begin
                w = IDLE_W; w.done = 1'b1;
                exp_q.push_back(w);
            end
        endcase
    endtask

    task automatic check_cycle(input string tag);
        cw_t exp;
        int  drivers;
        obs = sample_dut();
        if (exp_q.size() != 0) exp = exp_q[0];
        else begin
            exp = IDLE_W;
            exp.ir_in = bus.run;
        end
        chk(tag, 32'(obs), 32'(exp));
        drivers = $countones(obs.r_out) + int'(obs.g_out) + int'(obs.din_out);
        chk("bus_excl", 32'(drivers <= 1), 32'd1);
    endtask

    // One clock cycle: drive on the falling edge, check, then advance the model.
    task automatic step(input string tag, input logic r, input logic [15:0] d);
        @(negedge clock);
        bus.run = r;
        bus.din = d;
        #1;
        check_cycle(tag);
        @(posedge clock);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        else if (r) push_instr(d);
    endtask

    task automatic do_reset();
        @(negedge clock);
        bus.run = 1'b1;
        #1;
        check_cycle("pre_rst");
        #1;
        reset = 1'b1;
        #1;
        obs = sample_dut();
        chk("rst_word", 32'(obs), 32'(IDLE_W));
        exp_q.delete();
        @(posedge clock);
        @(negedge clock);
        #1;
        obs = sample_dut();
        chk("rst_hold", 32'(obs), 32'(IDLE_W));
        reset   = 1'b0;
        bus.run = 1'b0;
    endtask

    initial begin
        int b2b_at;
        int dones;
        bus.run = 1'b1;
        bus.din = 16'h0000;

        // Reset with run high: ir_in must stay low.
        #2;
        obs = sample_dut();
        chk("rst_init", 32'(obs), 32'(IDLE_W));
        @(negedge clock);
        reset = 1'b0;
        bus.run = 1'b0;

        // mv R3,R5
        step("mv_t0", 1'b1, 16'h001D);
        step("mv_t1", 1'b0, 16'h0000);
        chk("mv_rout", 32'(obs.r_out), 32'h20);
        chk("mv_rin",  32'(obs.r_in),  32'h08);
        chk("mv_done", 32'(obs.done),  32'd1);
        step("mv_back", 1'b0, 16'h0000);

        // mvi R7,#0xBEEF
        step("mvi_t0", 1'b1, 16'h0078);
        step("mvi_t1", 1'b0, 16'hBEEF);
        chk("mvi_dinout", 32'(obs.din_out), 32'd1);
        chk("mvi_rin",    32'(obs.r_in),    32'h80);

        // add R1,R2 with run wiggling mid-instruction
        step("add_t0", 1'b1, 16'h008A);
        step("add_t1", 1'b0, 16'h01C0);
        chk("add_t1_rout", 32'(obs.r_out), 32'h02);
        step("add_t2", 1'b1, 16'h001D);
        chk("add_t2_rout", 32'(obs.r_out), 32'h04);
        chk("add_t2_mode", 32'(obs.add_sub), 32'd1);
        step("add_t3", 1'b1, 16'h0078);
        chk("add_t3_rin", 32'(obs.r_in), 32'h02);
        step("add_idle", 1'b0, 16'h0000);

        // sub R0,R6 then mv R3,R5 back-to-back with run held high
        step("sub_t0", 1'b1, 16'h00C6);
        b2b_at = -1;
        dones  = 0;
        for (int i = 1; i <= 10 && b2b_at < 0; i++) begin
            step("b2b", 1'b1, 16'h001D);
            if (i == 2) chk("sub_t2_mode", 32'(obs.add_sub), 32'd0);
            if (obs.done) begin
                dones++;
                if (dones == 2) b2b_at = i;
            end
        end
        chk("b2b_latency", 32'(b2b_at), 32'd5);
        step("b2b_tail", 1'b0, 16'h0000);

        // Reserved opcode
        step("nop_t0", 1'b1, 16'h01C0);
        step("nop_t1", 1'b0, 16'h0000);
        chk("nop_done", 32'(obs.done), 32'd1);

        // Reset while in T2 of an add, then resume
        step("arst_t0", 1'b1, 16'h008A);
        step("arst_t1", 1'b0, 16'h0000);
        do_reset();
        step("resume_t0", 1'b1, 16'h001D);
        step("resume_t1", 1'b0, 16'h0000);

        // Random traffic, including rx==ry and occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            else step("rand", ($urandom_range(0, 3) != 0), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/proc_control.md
# proc_control

Sequencing control unit for the simple processor datapath. Captures a 9-bit instruction from the shared input bus and walks a four-step timing FSM (T0–T3). It drives register load/enable strobes, bus-source selects, and the `add_sub` mode line of the downstream 16-bit adder/subtractor. It pulses `done` when an instruction retires.

## Interface
- `N`, 16: datapath width; sizes `din`. IR and control widths are fixed.
- `NREG`, 8: number of general registers; sizes the one-hot select vectors. Fixed at 8 by the 3-bit register fields.
- `clock` in 1: rising-edge clock, single clock domain.
- `reset` in 1: asynchronous, active-high; clears FSM and IR.
- `run` in 1: request to fetch and execute the instruction on `din`.
- `din` in N: instruction word (bits [8:0]) or immediate operand.
- `ir_in` out 1: IR load strobe.
- `r_in` out NREG: one-hot register write enable.
- `r_out` out NREG: one-hot register bus-drive enable.
- `a_in` out 1: load operand register A.
- `g_in` out 1: load result register G from the adder output.
- `g_out` out 1: G drives the bus.
- `din_out` out 1: `din` drives the bus.
- `add_sub` out 1: adder mode; 1 = add, 0 = subtract.
- `done` out 1: one-cycle pulse in the last step of each instruction.

## Operation
- Encoding: opcode = IR[8:6], rx = IR[5:3], ry = IR[2:0]. `din[N-1:9]` is ignored on fetch.
- Opcodes:
  - 000 mv rx,ry
  - 001 mvi rx,#D
  - 010 add rx,ry
  - 011 sub rx,ry
  - 100–111 reserved, executed as NOP
- States: T0 (fetch/idle), T1, T2, T3. All outputs are combinational from state, IR, and `run` (in T0 only).
- T0:
  - `ir_in` = `run`. IR loads `din[8:0]` on the edge.
  - If `run`, go to T1; else stay in T0.
- T1 by opcode:
  - mv: `r_out`[ry], `r_in`[rx], `done`; go to T0.
  - mvi: `din_out`, `r_in`[rx], `done`; go to T0. The immediate is presented on `din` during T1.
  - add/sub: `r_out`[rx], `a_in`; go to T2.
  - reserved: `done` only, no strobes; go to T0.
- T2 (add/sub): `r_out`[ry], `g_in`, `add_sub` = 1 for add and 0 for sub; go to T3.
- T3 (add/sub): `g_out`, `r_in`[rx], `done`; go to T0.
- Outside T2, `add_sub` is held at 1 (add) so the adder mode never glitches during idle.
- At most one of `r_out` bits, `g_out`, `din_out` is high in any cycle. This is the bus-contention invariant.
- `run` is ignored in T1–T3. The IR is never reloaded mid-instruction.

## Timing
- Reset values:
  - state = T0, IR = 0.
  - While `reset` is high, every output is 0 except `add_sub` = 1.
  - `ir_in` is forced 0 during reset regardless of `run`.
- Reset mid-instruction: abort immediately (asynchronously). No partial `r_in` write occurs after `reset` rises.
- Latency from `run` sampled high in T0 to `done`:
  - 1 cycle for mv, mvi, and NOP (`done` in T1).
  - 3 cycles for add/sub (`done` in T3).
- Back-to-back: if `run` is high in the T0 cycle that follows `done`, the next fetch occurs with no bubble beyond that T0.
- rx = ry is legal. For add, the result is 2·Rx; for sub, it is 0. The control sequence is unchanged.
- Arithmetic is performed downstream modulo 2^N. Control generates no carry or overflow status.

## Structure
- Package `proc_pkg` holds:
  - opcode constants (`OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`)
  - the state encoding (`T0`–`T3`, 2-bit)
  - IR field positions
- Sub-module `dec3to8` (3-bit in, enable, 8-bit one-hot out) is instantiated twice, for `r_in` and `r_out`.
- State register and IR live in a single always block, using async reset.

## Test plan
- Reset with `run`=1: all outputs 0, `add_sub`=1. Release reset, `din`=0x01D (mv R3,R5) → T1: `r_out`=0x20, `r_in`=0x08, `done`=1. Next cycle back in T0.
- mvi R7: `din`=0x078, then `din`=0xBEEF in T1 → `din_out`=1, `r_in`=0x80, `done`=1 in T1.
- add R1,R2 (`din`=0x08A):
  - T1: `r_out`=0x02, `a_in`.
  - T2: `r_out`=0x04, `g_in`, `add_sub`=1.
  - T3: `g_out`, `r_in`=0x02, `done`.
  - Confirm `run` toggling during T1–T3 is ignored.
- sub R0,R6 (`din`=0x0C6): T2 shows `add_sub`=0. Back-to-back with mv R3,R5 (`run` held high) retires at cycle 5 after the first fetch.
- Reserved opcode `din`=0x1C0: T1 gives `done`=1 with `r_in`=`r_out`=0 and `a_in`=`g_in`=0.
- Assert `reset` during T2 of an add: outputs drop to reset values the same cycle, no `r_in` pulse, FSM resumes in T0.
- Throughout all tests, assert the one-hot bus-drive invariant every cycle.
